dm_responder: RTL and testbench

- Data-memory responder on the CPU's external data port; the memory-side end of the m_data_* interface driven by the pipelined core's M stage.
- Reads are combinational so the core's M-stage load extender sees data in the same cycle; byte-enabled writes commit on the clock edge.
- Each committed write also goes into a small trace FIFO, drained through a valid/ready handshake by the testbench or a logging unit.

---
 rtl/dm_responder_if.sv | 31 +++
 rtl/dm_responder.sv | 151 +++++++++++++++
 tb/tb_dm_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Bus bundle between the core's M-stage data port / trace consumer and dm_responder.
// slave = responder side, master = core + trace-consumer side.
interface dm_responder_if #(
  parameter int TRACE_DEPTH_LOG2 = 3,
  parameter int OVF_W            = 16
);
  logic [31:0]               m_data_addr;
  logic [31:0]               m_data_wdata;
  logic [3:0]                m_data_byteen;
  logic [31:0]               m_inst_addr;
  logic [31:0]               m_data_rdata;
  logic                      trace_valid;
  logic                      trace_ready;
  logic [31:0]               trace_pc;
  logic [31:0]               trace_addr;
  logic [31:0]               trace_data;
  logic [TRACE_DEPTH_LOG2:0] trace_count;
  logic [OVF_W-1:0]          trace_ovf;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_ovf
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_count, trace_ovf
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: combinational reads, byte-enabled writes, write-trace FIFO.
// Optional macro DM_BYTEEN_CHECK_EN rejects illegal/misaligned byteen and adds byteen_err.
module dm_responder #(
  parameter int DEPTH_LOG2       = 12,
  parameter int TRACE_DEPTH_LOG2 = 3,
  parameter int OVF_W            = 16
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
`ifdef DM_BYTEEN_CHECK_EN
  ,
  output logic           byteen_err
`endif
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int TDEPTH = 1 << TRACE_DEPTH_LOG2;
  localparam logic [TRACE_DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [TRACE_DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [TRACE_DEPTH_LOG2:0]   CNT_FULL = TDEPTH[TRACE_DEPTH_LOG2:0];
  localparam logic [OVF_W-1:0]            OVF_ONE = 1;

  logic [31:0]           mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_range;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic                  be_ok;
  logic                  do_write;

  assign word_idx         = bus.m_data_addr[DEPTH_LOG2+1:2];
  assign in_range         = (bus.m_data_addr[31:DEPTH_LOG2+2] == '0);
  assign old_word         = mem_reg[word_idx];
  assign bus.m_data_rdata = in_range ? old_word : 32'h0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = bus.m_data_byteen[gi] ? bus.m_data_wdata[8*gi +: 8]
                                                            : old_word[8*gi +: 8];
    end
  endgenerate

`ifdef DM_BYTEEN_CHECK_EN
  logic err_reg;

  // Each legal lane pattern must start exactly at the byte offset of the address.
  always_comb begin
    be_ok = 1'b0;
    case (bus.m_data_byteen)
      4'b0000: be_ok = 1'b1;
      4'b0001: be_ok = (bus.m_data_addr[1:0] == 2'd0);
      4'b0010: be_ok = (bus.m_data_addr[1:0] == 2'd1);
      4'b0100: be_ok = (bus.m_data_addr[1:0] == 2'd2);
      4'b1000: be_ok = (bus.m_data_addr[1:0] == 2'd3);
      4'b0011: be_ok = (bus.m_data_addr[1:0] == 2'd0);
      4'b1100: be_ok = (bus.m_data_addr[1:0] == 2'd2);
      4'b1111: be_ok = (bus.m_data_addr[1:0] == 2'd0);
      default: be_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (!be_ok) begin
      err_reg <= 1'b1;
    end
  end

  assign byteen_err = err_reg;
`else
  assign be_ok = 1'b1;
`endif

  assign do_write = (bus.m_data_byteen != 4'b0000) && in_range && be_ok;

  // Whole-array clear on reset rules out a block-RAM mapping; this is a register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= 32'h0;
      end
    end else if (do_write) begin
      mem_reg[word_idx] <= merged_word;
    end
  end

  logic [31:0]                 fifo_pc_reg   [TDEPTH];
  logic [31:0]                 fifo_addr_reg [TDEPTH];
  logic [31:0]                 fifo_data_reg [TDEPTH];
  logic [TRACE_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [TRACE_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [TRACE_DEPTH_LOG2:0]   count_reg;
  logic [OVF_W-1:0]            ovf_reg;
  logic [31:0]                 hold_pc_reg;
  logic [31:0]                 hold_addr_reg;
  logic [31:0]                 hold_data_reg;
  logic                        fifo_full;
  logic                        fifo_pop;
  logic                        fifo_push;

  assign fifo_full = (count_reg == CNT_FULL);
  assign fifo_pop  = (count_reg != '0) && bus.trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_push = do_write && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push && !reset) begin
      fifo_pc_reg[wr_ptr_reg]   <= bus.m_inst_addr;
      fifo_addr_reg[wr_ptr_reg] <= {bus.m_data_addr[31:2], 2'b00};
      fifo_data_reg[wr_ptr_reg] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      ovf_reg       <= '0;
      hold_pc_reg   <= 32'h0;
      hold_addr_reg <= 32'h0;
      hold_data_reg <= 32'h0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        hold_pc_reg   <= fifo_pc_reg[rd_ptr_reg];
        hold_addr_reg <= fifo_addr_reg[rd_ptr_reg];
        hold_data_reg <= fifo_data_reg[rd_ptr_reg];
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (do_write && fifo_full && !fifo_pop && (ovf_reg != '1)) begin
        ovf_reg <= ovf_reg + OVF_ONE;
      end
    end
  end

  assign bus.trace_valid = (count_reg != '0);
  assign bus.trace_count = count_reg;
  assign bus.trace_ovf   = ovf_reg;
  assign bus.trace_pc    = bus.trace_valid ? fifo_pc_reg[rd_ptr_reg]   : hold_pc_reg;
  assign bus.trace_addr  = bus.trace_valid ? fifo_addr_reg[rd_ptr_reg] : hold_addr_reg;
  assign bus.trace_data  = bus.trace_valid ? fifo_data_reg[rd_ptr_reg] : hold_data_reg;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: byte-merge memory model plus trace scoreboard queue.
module tb_dm_responder;
  localparam int DL = 12;
  localparam int TL = 3;
  localparam int OW = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_responder_if #(.TRACE_DEPTH_LOG2(TL), .OVF_W(OW)) bus ();

`ifdef DM_BYTEEN_CHECK_EN
  logic byteen_err;
  dm_responder #(.DEPTH_LOG2(DL), .TRACE_DEPTH_LOG2(TL), .OVF_W(OW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .byteen_err(byteen_err)
  );
`else
  dm_responder #(.DEPTH_LOG2(DL), .TRACE_DEPTH_LOG2(TL), .OVF_W(OW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  int          exp_ovf = 0;
  trace_t      sb_q[$];
  logic [31:0] model_mem [int];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'b0000;
    bus.m_inst_addr   = 32'h0;
    bus.trace_ready   = 1'b0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    int idx;
    if (addr >= 32'h4000) return 32'h0;
    idx = int'(addr[DL+1:2]);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  // Presents a write and updates the model; caller ends the cycle with end_write.
  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, input logic [31:0] pc);
    logic [31:0] merged;
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = data;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    if (addr < 32'h4000 && be != 4'b0000) begin
      merged = model_rd(addr);
      for (int i = 0; i < 4; i++)
        if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
      model_mem[int'(addr[DL+1:2])] = merged;
      if (exp_count < 8) begin
        sb_q.push_back('{pc, addr & ~32'h3, merged});
        exp_count++;
      end else if (exp_ovf < 65535) begin
        exp_ovf++;
      end
    end
  endtask

  task automatic end_write();
    tick();
    bus.m_data_byteen = 4'b0000;
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] pc);
    drive_write(addr, data, be, pc);
    end_write();
  endtask

  task automatic check_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus.m_data_addr   = addr;
    bus.m_data_byteen = 4'b0000;
    #1;
    checks++;
    if (bus.m_data_rdata !== exp) begin
      errors++;
      $display("FAIL %s rdata@%h got %h expected %h", name, addr, bus.m_data_rdata, exp);
    end else
      $display("ok   %s rdata@%h = %h", name, addr, bus.m_data_rdata);
  endtask

  task automatic check_status(input string name);
    checks++;
    if (bus.trace_valid !== (exp_count != 0) || bus.trace_count !== 4'(exp_count) ||
        bus.trace_ovf !== 16'(exp_ovf)) begin
      errors++;
      $display("FAIL %s status got valid=%b count=%0d ovf=%0d expected valid=%b count=%0d ovf=%0d",
               name, bus.trace_valid, bus.trace_count, bus.trace_ovf,
               exp_count != 0, exp_count, exp_ovf);
    end else
      $display("ok   %s status count=%0d ovf=%0d", name, exp_count, exp_ovf);
  endtask

  // Compares the current head to the scoreboard front and pops the model.
  task automatic check_head(input string name);
    trace_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected trace_valid=%b with empty scoreboard", name, bus.trace_valid);
      return;
    end
    e = sb_q.pop_front();
    exp_count--;
    if (bus.trace_valid !== 1'b1 || bus.trace_pc !== e.pc || bus.trace_addr !== e.addr ||
        bus.trace_data !== e.data) begin
      errors++;
      $display("FAIL %s head got v=%b pc=%h addr=%h data=%h expected v=1 pc=%h addr=%h data=%h",
               name, bus.trace_valid, bus.trace_pc, bus.trace_addr, bus.trace_data,
               e.pc, e.addr, e.data);
    end else
      $display("ok   %s trace pc=%h addr=%h data=%h", name, e.pc, e.addr, e.data);
  endtask

  task automatic drain(input string name);
    bus.trace_ready = 1'b1;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) begin
      #1;
      check_head(name);
      tick();
    end
    bus.trace_ready = 1'b0;
    #1;
    check_status({name, "_drained"});
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_status("reset");
    check_rd(32'h10, 32'h0, "reset_mem");
  endtask

  task automatic test_word_write();
    write(32'h10, 32'h1234_5678, 4'b1111, 32'h3000);
    check_rd(32'h10, 32'h1234_5678, "word_write");
    check_status("word_write");
    drain("word_write");
  endtask

  task automatic test_halfword();
    write(32'h12, 32'hABCD_0000, 4'b1100, 32'h3004);
    check_rd(32'h10, 32'hABCD_5678, "halfword");
    drain("halfword");
  endtask

  task automatic test_same_cycle();
    drive_write(32'h20, 32'hFFFF_FFFF, 4'b1111, 32'h3008);
    #1;
    checks++;
    if (bus.m_data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL same_cycle_old rdata got %h expected %h", bus.m_data_rdata, 32'h0);
    end else
      $display("ok   same_cycle_old rdata = %h", bus.m_data_rdata);
    end_write();
    check_rd(32'h20, 32'hFFFF_FFFF, "same_cycle_new");
    drain("same_cycle");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++)
      write(32'h100 + 32'(4*i), 32'h1111_1111 * 32'(i + 1), 4'b1111, 32'h4000 + 32'(4*i));
    check_status("overflow_full");
    // Push and pop together while full: occupancy and overflow count must not move.
    bus.trace_ready = 1'b1;
    #1;
    check_head("full_pop");
    drive_write(32'h200, 32'hCAFE_F00D, 4'b1111, 32'h4100);
    end_write();
    bus.trace_ready = 1'b0;
    check_status("full_push_pop");
    drain("overflow");
  endtask

  task automatic test_out_of_range();
    write(32'h0001_0000, 32'hDEAD_BEEF, 4'b1111, 32'h5000);
    check_status("out_of_range");
    check_rd(32'h0001_0000, 32'h0, "oor_read");
    check_rd(32'h0, 32'h0, "oor_no_alias");
  endtask

  task automatic test_back_to_back();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [3:0]  be;
      logic [31:0] off;
      be  = (i == 4) ? 4'b1111 : 4'(1 << i);
      off = (i == 4) ? 32'h4 : 32'(i);
      #1;
      if (sb_q.size() != 0) check_head("b2b");
      drive_write(32'h80 + off, {4{8'(8'hA0 + i)}}, be, 32'h6000 + 32'(4*i));
      end_write();
    end
    drain("b2b");
    check_rd(32'h80, 32'hA3A2_A1A0, "b2b_bytes");
    check_rd(32'h84, 32'hA4A4_A4A4, "b2b_word");
  endtask

  task automatic test_mid_reset();
    write(32'h40, 32'h0000_0040, 4'b1111, 32'h7000);
    write(32'h44, 32'h0000_0044, 4'b1111, 32'h7004);
    write(32'h48, 32'h0000_0048, 4'b1111, 32'h7008);
    check_status("pre_reset");
    reset = 1'b1;
    bus.m_data_addr   = 32'h4C;
    bus.m_data_wdata  = 32'h5555_5555;
    bus.m_data_byteen = 4'b1111;
    bus.m_inst_addr   = 32'h700C;
    tick();
    reset = 1'b0;
    idle();
    sb_q.delete();
    model_mem.delete();
    exp_count = 0;
    exp_ovf   = 0;
    #1;
    check_status("mid_reset");
    check_rd(32'h40, 32'h0, "mid_reset_40");
    check_rd(32'h10, 32'h0, "mid_reset_10");
    check_rd(32'h4C, 32'h0, "mid_reset_4c");
  endtask

`ifdef DM_BYTEEN_CHECK_EN
  task automatic test_byteen_check();
    bus.m_data_addr   = 32'h50;
    bus.m_data_wdata  = 32'h1234_5678;
    bus.m_data_byteen = 4'b0101;
    bus.m_inst_addr   = 32'h8000;
    tick();
    idle();
    #1;
    checks++;
    if (byteen_err !== 1'b1) begin
      errors++;
      $display("FAIL byteen_err got %b expected 1", byteen_err);
    end else
      $display("ok   byteen_err = 1");
    check_status("byteen_bad");
    check_rd(32'h50, 32'h0, "byteen_bad_mem");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_write();
    test_halfword();
    test_same_cycle();
    test_overflow();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
`ifdef DM_BYTEEN_CHECK_EN
    test_byteen_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
